// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters share one ALUdec/ALU pair, result registered with requester ID.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties; default build gives requester 0 priority.
package alu_share_arb_pkg;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;

    localparam logic [2:0] FNC_ADD_SUB = 3'b000;
    localparam logic [2:0] FNC_SLL     = 3'b001;
    localparam logic [2:0] FNC_SLT     = 3'b010;
    localparam logic [2:0] FNC_SLTU    = 3'b011;
    localparam logic [2:0] FNC_XOR     = 3'b100;
    localparam logic [2:0] FNC_SRL_SRA = 3'b101;
    localparam logic [2:0] FNC_OR      = 3'b110;
    localparam logic [2:0] FNC_AND     = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
    } alu_op_t;
endpackage

module ALUdec
    import alu_share_arb_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct,
    input  logic       i_add_rshift_type,
    output alu_op_t    o_alu_op
);
    logic w_is_r;
    assign w_is_r = (i_opcode == OPC_ARI_RTYPE);

    always_comb begin
        o_alu_op = ALU_ADD;
        if (i_opcode == OPC_LUI) begin
            o_alu_op = ALU_COPY_B;
        end else if (w_is_r || i_opcode == OPC_ARI_ITYPE) begin
            unique case (i_funct)
                FNC_ADD_SUB: o_alu_op = (w_is_r && i_add_rshift_type) ? ALU_SUB : ALU_ADD;
                FNC_SLL:     o_alu_op = ALU_SLL;
                FNC_SLT:     o_alu_op = ALU_SLT;
                FNC_SLTU:    o_alu_op = ALU_SLTU;
                FNC_XOR:     o_alu_op = ALU_XOR;
                FNC_SRL_SRA: o_alu_op = i_add_rshift_type ? ALU_SRA : ALU_SRL;
                FNC_OR:      o_alu_op = ALU_OR;
                FNC_AND:     o_alu_op = ALU_AND;
            endcase
        end
    end
endmodule

module ALU
    import alu_share_arb_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] i_a,
    input  logic [DWIDTH-1:0] i_b,
    input  alu_op_t           i_op,
    output logic [DWIDTH-1:0] o_out
);
    logic signed [DWIDTH-1:0] w_sra;
    logic [4:0]               w_sh;
    assign w_sh  = i_b[4:0];
    assign w_sra = $signed(i_a) >>> w_sh;

    always_comb begin
        o_out = '0;
        case (i_op)
            ALU_ADD:    o_out = i_a + i_b;
            ALU_SUB:    o_out = i_a - i_b;
            ALU_SLL:    o_out = i_a << w_sh;
            ALU_SLT:    o_out = {{(DWIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_SLTU:   o_out = {{(DWIDTH-1){1'b0}}, i_a < i_b};
            ALU_XOR:    o_out = i_a ^ i_b;
            ALU_SRL:    o_out = i_a >> w_sh;
            ALU_SRA:    o_out = w_sra;
            ALU_OR:     o_out = i_a | i_b;
            ALU_AND:    o_out = i_a & i_b;
            ALU_COPY_B: o_out = i_b;
            default:    o_out = '0;
        endcase
    end
endmodule

module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [6:0]        req0_opcode,
    input  logic [2:0]        req0_funct,
    input  logic              req0_add_rshift_type,
    input  logic [DWIDTH-1:0] req0_A,
    input  logic [DWIDTH-1:0] req0_B,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [6:0]        req1_opcode,
    input  logic [2:0]        req1_funct,
    input  logic              req1_add_rshift_type,
    input  logic [DWIDTH-1:0] req1_A,
    input  logic [DWIDTH-1:0] req1_B,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DWIDTH-1:0] res_out,
    output logic              res_id
);
    logic              r_last_grant;
    logic              r_res_valid;
    logic [DWIDTH-1:0] r_res_out;
    logic              r_res_id;

    logic              w_can_issue;
    logic              w_tie_pick;
    logic              w_winner;
    logic              w_fire;
    logic [6:0]        w_opcode;
    logic [2:0]        w_funct;
    logic              w_type;
    logic [DWIDTH-1:0] w_a;
    logic [DWIDTH-1:0] w_b;
    logic [DWIDTH-1:0] w_alu_out;
    alu_op_t           w_alu_op;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    assign w_tie_pick = ~r_last_grant;
`else
    // last_grant is tracked in both builds; fixed priority simply ignores it
    assign w_tie_pick = r_last_grant & 1'b0;
`endif

    assign w_can_issue = !Reset && (!r_res_valid || res_ready);
    assign w_winner    = (req0_valid && req1_valid) ? w_tie_pick : req1_valid;
    assign req0_ready  = w_can_issue && req0_valid && !w_winner;
    assign req1_ready  = w_can_issue && req1_valid && w_winner;
    assign w_fire      = req0_ready || req1_ready;

    assign w_opcode = w_winner ? req1_opcode : req0_opcode;
    assign w_funct  = w_winner ? req1_funct : req0_funct;
    assign w_type   = w_winner ? req1_add_rshift_type : req0_add_rshift_type;
    assign w_a      = w_winner ? req1_A : req0_A;
    assign w_b      = w_winner ? req1_B : req0_B;

    ALUdec u_dec (
        .i_opcode          (w_opcode),
        .i_funct           (w_funct),
        .i_add_rshift_type (w_type),
        .o_alu_op          (w_alu_op)
    );

    ALU #(.DWIDTH(DWIDTH)) u_alu (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_op  (w_alu_op),
        .o_out (w_alu_out)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_res_valid  <= 1'b0;
            r_res_out    <= '0;
            r_res_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_fire) begin
            r_res_valid  <= 1'b1;
            r_res_out    <= w_alu_out;
            r_res_id     <= w_winner;
            r_last_grant <= w_winner;
        end else if (res_ready) begin
            r_res_valid  <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_out   = r_res_out;
    assign res_id    = r_res_id;
endmodule
